// File: rtl/mc_control_unit_if.sv
// Control-unit bus: instruction fields and ALU flag in, datapath controls and debug out.
// The control unit takes the master modport; the datapath side takes the slave modport.
interface mc_control_unit_if #(
    parameter int unsigned STATE_W = 4
);
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               Zero;
    logic               PCWrite;
    logic               AdrSrc;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegWrite;
    logic [1:0]         ResultSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ImmSrc;
    logic [2:0]         ALUControl;
    logic               retire;
    logic               illegal;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
        output ImmSrc, ALUControl, retire, illegal, state_dbg
    );

    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
        input  ImmSrc, ALUControl, retire, illegal, state_dbg
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle RV32 control unit: main FSM with registered Moore controls plus ALU decoder.
// Supports lw, sw, R-type, I-type ALU, beq and jal; unknown opcodes lock into TRAP.
module mc_control_unit #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mc_control_unit_if.master  bus
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StAluWb    = 4'd7,
        StExecuteI = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10,
        StTrap     = 4'd11
    } state_e;

    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpI    = 7'b0010011;
    localparam logic [6:0] OpBeq  = 7'b1100011;
    localparam logic [6:0] OpJal  = 7'b1101111;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    state_e state_q, state_d;
    ctrl_t  ctrl_q;

    // Control word for a state; registered alongside the state so outputs come straight from flops.
    function automatic ctrl_t ctrl_for(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.ir_write   = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.pc_update  = 1'b1;
            end
            StDecode: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            StMemAdr: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            StMemRead: begin
                c.adr_src = 1'b1;
            end
            StMemWb: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            StMemWrite: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
                c.retire    = 1'b1;
            end
            StExecuteR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = AluOpFunct;
            end
            StExecuteI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = AluOpFunct;
            end
            StAluWb: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            StBeq: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = AluOpSub;
                c.branch    = 1'b1;
                c.retire    = 1'b1;
            end
            StJal: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            StTrap: begin
                c.illegal = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    state_d = StDecode;
            StDecode: begin
                case (bus.op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpR:        state_d = StExecuteR;
                    OpI:        state_d = StExecuteI;
                    OpBeq:      state_d = StBeq;
                    OpJal:      state_d = StJal;
                    default:    state_d = StTrap;
                endcase
            end
            StMemAdr:   state_d = (bus.op == OpSw) ? StMemWrite : StMemRead;
            StMemRead:  state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = StFetch;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            StJal:      state_d = StAluWb;
            StTrap:     state_d = StTrap;
            default:    state_d = StTrap;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            ctrl_q  <= ctrl_for(StFetch);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for(state_d);
        end
    end

    // Enables are masked by rst_n so a mid-instruction reset kills every write at once, while
    // the FETCH controls are already in place for the first edge after release.
    assign bus.PCWrite  = rst_n & (ctrl_q.pc_update | (ctrl_q.branch & bus.Zero));
    assign bus.IRWrite  = rst_n & ctrl_q.ir_write;
    assign bus.MemWrite = rst_n & ctrl_q.mem_write;
    assign bus.RegWrite = rst_n & ctrl_q.reg_write;
    assign bus.retire   = rst_n & ctrl_q.retire;
    assign bus.illegal  = rst_n & ctrl_q.illegal;

    assign bus.AdrSrc    = ctrl_q.adr_src;
    assign bus.ResultSrc = ctrl_q.result_src;
    assign bus.ALUSrcA   = ctrl_q.alu_src_a;
    assign bus.ALUSrcB   = ctrl_q.alu_src_b;
    assign bus.state_dbg = STATE_W'(state_q);

    always_comb begin
        case (bus.op)
            OpSw:    bus.ImmSrc = 2'b01;
            OpBeq:   bus.ImmSrc = 2'b10;
            OpJal:   bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    // Only R-type (op[5] set) turns funct3=000 with funct7b5 into sub; addi never does.
    always_comb begin
        bus.ALUControl = AluAdd;
        case (ctrl_q.alu_op)
            AluOpSub: bus.ALUControl = AluSub;
            AluOpFunct: begin
                case (bus.funct3)
                    3'b000:  bus.ALUControl = (bus.op[5] & bus.funct7b5) ? AluSub : AluAdd;
                    3'b010:  bus.ALUControl = AluSlt;
                    3'b110:  bus.ALUControl = AluOr;
                    3'b111:  bus.ALUControl = AluAnd;
                    default: bus.ALUControl = AluAdd;
                endcase
            end
            default: bus.ALUControl = AluAdd;
        endcase
    end

endmodule
